// File: rtl/axis_spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axis_spi_pkg                                            |
// | Purpose  : Shared types and constants for the AXI-Stream SPI        |
// |            register access controller.                              |
// | Contents : state_t (controller FSM states), CMD_RW_BIT (position    |
// |            of the read/write flag in the command byte), READ_FILL   |
// |            (dummy byte clocked out during a read).                  |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package axis_spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DATA    = 3'd2,
    COLLECT = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam int         CMD_RW_BIT = 7;
  localparam logic [7:0] READ_FILL  = 8'h00;

endpackage
`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axis_if                                                 |
// | Purpose  : Minimal AXI-Stream bundle (tvalid/tready/tdata/tlast).   |
// | Ports    : none; modport master drives tvalid/tdata/tlast,          |
// |            modport slave drives tready.                             |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
interface axis_if #(
  parameter int DATA_W = 8
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_spi_reg_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axis_spi_reg_ctrl                                       |
// | Purpose  : Turns register read/write requests into an SPI byte      |
// |            frame ({rw,addr} then DATA_BYTES data bytes) on m_axis,  |
// |            collects the echoed bytes on s_axis and returns read     |
// |            data / error status on the response channel.             |
// | Ports    : clk_i, arst_i (async, active-high)                       |
// |            req_*  : request channel (valid/ready, rw, addr, slave,  |
// |                     wdata)                                          |
// |            rsp_*  : response channel (valid/ready, rdata, err)      |
// |            spi_addr_o : chip select index for the SPI master        |
// |            m_axis : bytes to SPI master, s_axis : bytes from it     |
// | Options  : define SPI_REG_TIMEOUT_EN to build the inactivity        |
// |            timeout (TIMEOUT cycles); otherwise it waits forever.    |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module axis_spi_reg_ctrl
  import axis_spi_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter int SLAVE_NUM  = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_rw_i,
  input  logic [6:0]                   req_addr_i,
  input  logic [$clog2(SLAVE_NUM)-1:0] req_slave_i,
  input  logic [8*DATA_BYTES-1:0]      req_wdata_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [8*DATA_BYTES-1:0]      rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic [$clog2(SLAVE_NUM)-1:0] spi_addr_o,
  axis_if.master                       m_axis,
  axis_if.slave                        s_axis
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam int SW    = $clog2(SLAVE_NUM);
  localparam int TXC_W = $clog2(DATA_BYTES + 1);
  localparam int RXC_W = $clog2(DATA_BYTES + 2);
  localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(DATA_BYTES - 1);
  localparam logic [RXC_W-1:0] RX_FINAL = RXC_W'(DATA_BYTES);

  state_t             state_q, state_d;
  logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [RXC_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic               rw_q, rw_d;
  logic [6:0]         addr_q, addr_d;
  logic [SW-1:0]      slave_q, slave_d;
  logic [DW-1:0]      tx_shift_q, tx_shift_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               err_q, err_d;
  // Receive side has seen its last byte (count reached or early tlast);
  // the FSM may still be finishing the transmit frame.
  logic               done_q, done_d;

  logic               tx_valid;
  logic               tx_last;
  logic [7:0]         tx_data;
  logic [7:0]         cmd_byte;
  logic               m_hs;
  logic               s_hs;
  logic               rx_fire;
  logic               rx_final;
  logic               rx_early;
  logic               rx_end;

  // Transmit-side outputs come straight from state so tvalid/tdata/tlast
  // are stable while the FSM waits for tready.
  always_comb begin
    cmd_byte             = {1'b0, addr_q};
    cmd_byte[CMD_RW_BIT] = rw_q;
    tx_valid             = (state_q == CMD) || (state_q == DATA);
    tx_last              = (state_q == DATA) && (tx_cnt_q == TX_LAST);
    tx_data              = 8'h00;
    if (state_q == CMD) begin
      tx_data = cmd_byte;
    end else if (state_q == DATA) begin
      tx_data = tx_shift_q[DW-1 -: 8];
    end
  end

  assign m_axis.tvalid = tx_valid;
  assign m_axis.tdata  = tx_data;
  assign m_axis.tlast  = tx_last;

  // IDLE is the reset state, so ready flags are masked while arst_i is high.
  assign req_ready_o   = (state_q == IDLE) && !arst_i;
  assign s_axis.tready = (state_q != RESP) && !arst_i;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign spi_addr_o    = slave_q;

  assign m_hs     = tx_valid && m_axis.tready;
  assign s_hs     = s_axis.tvalid && s_axis.tready;
  assign rx_fire  = s_hs && !done_q &&
                    ((state_q == CMD) || (state_q == DATA) || (state_q == COLLECT));
  assign rx_final = rx_fire && (rx_cnt_q == RX_FINAL);
  assign rx_early = rx_fire && s_axis.tlast && (rx_cnt_q != RX_FINAL);
  assign rx_end   = rx_final || rx_early;

`ifdef SPI_REG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    slave_d    = slave_q;
    tx_shift_d = tx_shift_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    done_d     = done_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          rw_d       = req_rw_i;
          addr_d     = req_addr_i;
          slave_d    = req_slave_i;
          tx_shift_d = req_rw_i ? {DATA_BYTES{READ_FILL}} : req_wdata_i;
          rdata_d    = '0;
          err_d      = 1'b0;
          done_d     = 1'b0;
          tx_cnt_d   = '0;
          rx_cnt_d   = '0;
          state_d    = CMD;
        end
      end
      CMD: begin
        if (m_hs) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (m_hs) begin
          tx_shift_d = tx_shift_q << 8;
          tx_cnt_d   = tx_cnt_q + TXC_W'(1);
          if (tx_cnt_q == TX_LAST) begin
            // Receive side may already be finished (early tlast, or the
            // final echo arriving with this very handshake).
            state_d = (done_q || rx_end) ? RESP : COLLECT;
          end
        end
      end
      COLLECT: begin
        if (rx_end) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Receive path runs independently of the transmit handshake.
    if (rx_fire) begin
      rx_cnt_d = rx_cnt_q + RXC_W'(1);
      if ((rx_cnt_q != '0) && rw_q) begin
        rdata_d = (rdata_q << 8) | DW'(s_axis.tdata);
      end
      if (rx_final && !s_axis.tlast) begin
        err_d = 1'b1;
      end
      if (rx_early) begin
        err_d = 1'b1;
      end
      if (rx_end) begin
        done_d = 1'b1;
      end
    end

`ifdef SPI_REG_TIMEOUT_EN
    tmo_cnt_d = '0;
    if ((state_q == CMD) || (state_q == DATA) || (state_q == COLLECT)) begin
      if (m_hs || s_hs) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TMO_MAX) begin
        state_d = RESP;
        err_d   = 1'b1;
        rdata_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      slave_q    <= '0;
      tx_shift_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPI_REG_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      slave_q    <= slave_d;
      tx_shift_q <= tx_shift_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      done_q     <= done_d;
`ifdef SPI_REG_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/axis_spi_reg_ctrl.md
AXIS_SPI_REG_CTRL -- requirements
Module: axis_spi_reg_ctrl

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 2: register data bytes per access.
REQ-002 SHALL have parameter SLAVE_NUM, default 2: number of SPI chip selects.
REQ-003 SHALL have parameter TIMEOUT, default 1024: maximum clk_i cycles between transmitted byte and received byte.
REQ-004 Ports, in order:
- clk_i  in  1  single clock.
- arst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_rw_i  in  1  1=read, 0=write.
- req_addr_i  in  7  register address.
- req_slave_i  in  $clog2(SLAVE_NUM)  target slave.
- req_wdata_i  in  8*DATA_BYTES  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_rdata_o  out  8*DATA_BYTES  read data; 0 for writes.
- rsp_err_o  out  1  timeout or framing error.
- spi_addr_o  out  $clog2(SLAVE_NUM)  slave select to SPI master.
- m_axis  axis_if.master  8-bit byte stream to SPI master.
- s_axis  axis_if.slave  8-bit received bytes from SPI master.

Function
REQ-005 SHALL use states IDLE, CMD, DATA, COLLECT, RESP.
REQ-006 IDLE: req_ready_o=1; on req_valid_i&req_ready_o, latch the request and go to CMD.
REQ-007 CMD: m_axis.tvalid=1 with tdata={rw,addr[6:0]} and tlast=0; on m_axis handshake, go to DATA.
REQ-008 DATA: SHALL send DATA_BYTES bytes, MSB byte first; write sends req_wdata_i bytes; read sends 0x00.
REQ-009 SHALL set tlast=1 only on the final DATA byte; after its handshake, go to COLLECT.
REQ-010 m_axis.tvalid SHALL assert on the cycle after request acceptance.
REQ-011 Once asserted, m_axis.tvalid SHALL stay high with tdata and tlast stable until tready.
REQ-012 s_axis.tready SHALL be 1 in all states except RESP.
REQ-013 s_axis bytes received outside CMD, DATA or COLLECT SHALL be discarded.
REQ-014 SHALL count received bytes: the first byte (command phase) is discarded; the next DATA_BYTES bytes are shifted into rdata MSB first on reads; rdata stays 0 on writes.
REQ-015 SHALL leave COLLECT for RESP when DATA_BYTES+1 bytes have been received.
REQ-016 A received byte with s_axis.tlast=1 before byte DATA_BYTES+1 SHALL set err and go to RESP.
REQ-017 Final byte without tlast SHALL set err.
REQ-018 RESP: rsp_valid_o=1, holding rdata and err stable until rsp_ready_i; on handshake, return to IDLE.
REQ-019 rsp_valid_o SHALL assert on the cycle after the final received byte.
REQ-020 spi_addr_o SHALL hold the latched slave from acceptance until the RESP handshake.
REQ-021 Received and transmitted bytes SHALL be counted independently; a received byte arriving in the same cycle as a transmit handshake SHALL be counted.

Reset
REQ-022 arst_i high SHALL, asynchronously, force state IDLE and clear all counters.
REQ-023 During reset, outputs SHALL be: req_ready_o=0, m_axis.tvalid=0, tdata=0, tlast=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, spi_addr_o=0; s_axis.tready=0.
REQ-024 Reset mid-transaction SHALL abandon the transaction and produce no response.

Configuration
REQ-025 SHALL compile the timeout counter only when SPI_REG_TIMEOUT_EN is defined. With the macro:
- the counter restarts on each m_axis handshake and each s_axis byte;
- in CMD, DATA or COLLECT, after TIMEOUT cycles without either event, SHALL set err and go to RESP with rdata=0.
REQ-026 Without SPI_REG_TIMEOUT_EN, SHALL wait indefinitely; rsp_err_o reflects framing errors only.

Structure
REQ-027 Package axis_spi_pkg SHALL hold the state enum typedef, the CMD_RW_BIT=7 constant and the READ_FILL=8'h00 constant.
REQ-028 No sub-module; the byte shift registers and counters SHALL be in this module.

Verification
REQ-029 Write, addr 0x15, wdata 0xBEEF -> m_axis bytes 0x15,0xBE,0xEF, tlast on 0xEF; s_axis returns 3 bytes with tlast on the third -> rsp rdata 0x0000, err 0.
REQ-030 Read, addr 0x2A, slave 1 -> bytes 0xAA,0x00,0x00; spi_addr_o=1 throughout; rx 0xFF,0x12,0x34 with tlast on 0x34 -> rdata 0x1234, err 0.
REQ-031 m_axis.tready low 5 cycles on each byte; rsp_ready_i low 3 cycles -> tdata and rsp fields stable, no byte lost or duplicated, req_ready_o=0 until the RESP handshake.
REQ-032 s_axis tlast on the 2nd received byte -> err 1, response issued, back to IDLE.
REQ-033 With SPI_REG_TIMEOUT_EN and TIMEOUT=16, no rx bytes -> rsp_valid_o rises 17 cycles after the last transmit handshake, err 1; without the macro -> no response.
REQ-034 arst_i pulsed during DATA -> all outputs at reset values, no response; next request completes correctly.
